ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit in EX. Consumes the ID/EX pipe outputs (alu_op, data1, data2).
//  Stalls IF/ID/ID-EX via busywait until the result is ready. Hands the result to the EX/MEM write-back path.
//  Handles MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
// PARAMETERS
//  XLEN    32                operand/result width
//  CNT_W   $clog2(XLEN)+1    iteration counter width; derived, do not override
// PORTS
//  clk             in   1     rising-edge clock
//  reset           in   1     asynchronous, active-low reset (asserted = 0)
//  start_i         in   1     ID/EX holds an M-ext op (alu_op in M range, reg_write_en=1)
//  flush_i         in   1     branch/jump redirect; abort any op in flight
//  hold_i          in   1     downstream busywait (memory); freeze result in DONE
//  alu_op_i        in   5     ID/EX alu_op
//  operand_a_i     in   XLEN  rs1 value after forwarding mux
//  operand_b_i     in   XLEN  rs2 value after forwarding mux
//  result_o        out  XLEN  rd value; valid while result_valid_o=1
//  result_valid_o  out  1     result available this cycle
//  stall_o         out  1     OR'd into busywait for IF/ID and ID/EX pipes
// BEHAVIOUR
//  Reset: state=IDLE, result_o=0, result_valid_o=0, counter=0, stall_o=0.
//  States:
//   IDLE -> CALC on start_i & !flush_i (normal case).
//   IDLE -> DONE on start_i & !flush_i when the op is a special case.
//   CALC -> DONE when count reaches XLEN.
//   DONE -> IDLE when !hold_i.
//  stall_o: combinational (IDLE & start_i & !flush_i) | CALC. It is 0 in DONE, so the pipe advances exactly once.
//  start_i is ignored in CALC and DONE; the same instruction still sits in ID/EX.
//  Latency: start sampled at edge N -> CALC for XLEN cycles -> result_valid_o=1 at cycle N+XLEN+1.
//   result_valid_o stays 1 while DONE & hold_i; result_o is stable throughout.
//  Operand handling: operands are latched at IDLE->CALC. Signedness per op (MULHSU: a signed, b unsigned).
//   Magnitudes are iterated unsigned; the sign is applied at DONE entry.
//  Multiply: shift-add, 2*XLEN accumulator. MUL returns the low XLEN bits; MULH* return the high XLEN bits.
//  Divide: restoring, one quotient bit per cycle.
//   Remainder sign = dividend sign. Quotient sign = a^b sign.
//  Special cases (1-cycle, IDLE->DONE):
//   divisor 0:             DIV/DIVU -> all ones; REM/REMU -> a.
//   DIV -2^(XLEN-1) / -1:  quotient = -2^(XLEN-1); REM -> 0.
//  flush_i in any state: next state IDLE, result_valid_o=0 next cycle, no result produced. flush_i has priority over start_i.
//  Reset mid-op: immediate return to IDLE; all outputs return to their reset values.
//  Non-M alu_op with start_i=1: treat as a protocol error. SVA assertion fires; the unit stays in IDLE.
// STRUCTURE
//  riscv_pkg:
//   ALU_MUL=5'b10000, ALU_MULH=5'b10001, ALU_MULHSU=5'b10010, ALU_MULHU=5'b10011,
//   ALU_DIV=5'b10100, ALU_DIVU=5'b10101, ALU_REM=5'b10110, ALU_REMU=5'b10111
//   is_mdu_op() function
//   muldiv_state_t enum {IDLE, CALC, DONE}
//  One sub-module: mdu_sign_ctrl. It is combinational: abs/negate and the final sign fix-up.
//  The FSM, counter and datapath registers live in ex_muldiv_unit.
// TESTING
//  1. MUL a=7, b=-3 -> stall_o high 33 cycles, result_o=32'hFFFFFFEB, result_valid_o for 1 cycle.
//  2. MULHU a=b=32'hFFFFFFFF -> result_o=32'hFFFFFFFE. MULH same operands -> 32'h00000000.
//  3. DIV a=-7, b=2 -> result_o=32'hFFFFFFFD. REM same operands -> 32'hFFFFFFFF.
//  4. DIVU by 0 -> result_o=32'hFFFFFFFF. REM a=5, b=0 -> 5. DIV 32'h80000000 by -1 -> 32'h80000000.
//     All three: result_valid_o exactly 1 cycle after start.
//  5. flush_i at CALC cycle 10 -> IDLE next cycle, result_valid_o never rises. A new start 1 cycle later computes correctly.
//  6. hold_i=1 for 3 cycles in DONE -> result_valid_o/result_o held 4 cycles.
//     Then reset pulsed low mid-CALC -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32M encodings, FSM state type and opcode decode helpers for the EX-stage multiply/divide unit.
package riscv_pkg;

  localparam logic [4:0] ALU_MUL    = 5'b10000;
  localparam logic [4:0] ALU_MULH   = 5'b10001;
  localparam logic [4:0] ALU_MULHSU = 5'b10010;
  localparam logic [4:0] ALU_MULHU  = 5'b10011;
  localparam logic [4:0] ALU_DIV    = 5'b10100;
  localparam logic [4:0] ALU_DIVU   = 5'b10101;
  localparam logic [4:0] ALU_REM    = 5'b10110;
  localparam logic [4:0] ALU_REMU   = 5'b10111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  function automatic logic is_mdu_op(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem_op(input logic [4:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/mdu_sign_ctrl.sv
// Sign handling for the iterative multiply/divide unit: operand magnitudes on entry and
// the final sign fix-up / result selection from the unsigned accumulator.
module mdu_sign_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]        i_op,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  output logic [XLEN-1:0]   o_a_mag,
  output logic [XLEN-1:0]   o_b_mag,
  output logic              o_neg,
  input  logic [4:0]        i_res_op,
  input  logic              i_res_neg,
  input  logic [2*XLEN-1:0] i_acc,
  output logic [XLEN-1:0]   o_result
);

  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_div_raw;
  logic [XLEN-1:0]   w_div_fix;

  // MULHSU treats only rs1 as signed; the *U ops treat neither as signed.
  always_comb begin
    w_a_signed = (i_op != ALU_MULHU) && (i_op != ALU_DIVU) && (i_op != ALU_REMU);
    w_b_signed = w_a_signed && (i_op != ALU_MULHSU);
    w_a_neg    = w_a_signed & i_a[XLEN-1];
    w_b_neg    = w_b_signed & i_b[XLEN-1];
    o_a_mag    = w_a_neg ? -i_a : i_a;
    o_b_mag    = w_b_neg ? -i_b : i_b;
    o_neg      = is_rem_op(i_op) ? w_a_neg : (w_a_neg ^ w_b_neg);
  end

  // NOTE: every output of a combinational block is assigned on every path first, so no latch is inferred.
  always_comb begin
    w_prod    = i_res_neg ? -i_acc : i_acc;
    w_div_raw = is_rem_op(i_res_op) ? i_acc[2*XLEN-1:XLEN] : i_acc[XLEN-1:0];
    w_div_fix = i_res_neg ? -w_div_raw : w_div_raw;
    o_result  = w_div_fix;
    if (!is_div_op(i_res_op)) begin
      o_result = (i_res_op == ALU_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply, restoring divide,
// one bit per cycle, stalling the front of the pipe until the result is ready.
module ex_muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic            hold_i,
  input  logic [4:0]      alu_op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o,
  output logic            stall_o
);

  localparam int              CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] SMIN  = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     r_state;
  logic [4:0]        r_op;
  logic              r_neg;
  logic [XLEN-1:0]   r_opnd;
  logic [2*XLEN-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_result;
  logic              r_valid;

  logic              w_start;
  logic              w_div_zero;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_neg;
  logic [XLEN-1:0]   w_fixed;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_diff;
  logic              w_qbit;
  logic [2*XLEN-1:0] w_acc_next;

  assign w_start        = start_i & ~flush_i & is_mdu_op(alu_op_i);
  assign stall_o        = reset & (((r_state == IDLE) & w_start) | (r_state == CALC));
  assign result_o       = r_result;
  assign result_valid_o = r_valid;
  assign w_cnt_next     = r_cnt + CNT_W'(1);

  // Divide-by-zero and signed overflow are answered directly, skipping the iteration.
  always_comb begin
    w_div_zero = is_div_op(alu_op_i) && (operand_b_i == '0);
    w_ovf      = ((alu_op_i == ALU_DIV) || (alu_op_i == ALU_REM)) &&
                 (operand_a_i == SMIN) && (operand_b_i == '1);
    w_special  = w_div_zero | w_ovf;
    if (w_div_zero) begin
      w_special_res = is_rem_op(alu_op_i) ? operand_a_i : '1;
    end else begin
      w_special_res = is_rem_op(alu_op_i) ? '0 : SMIN;
    end
  end

  // Multiply keeps {partial, multiplier} in r_acc; divide keeps {remainder, quotient}.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
    w_diff     = w_rem_sh - {1'b0, r_opnd};
    w_qbit     = ~w_diff[XLEN];
    w_acc_next = is_div_op(r_op)
               ? {(w_qbit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_qbit}
               : {w_mul_sum, r_acc[XLEN-1:1]};
  end

  mdu_sign_ctrl #(.XLEN(XLEN)) u_sign_ctrl (
    .i_op      (alu_op_i),
    .i_a       (operand_a_i),
    .i_b       (operand_b_i),
    .o_a_mag   (w_a_mag),
    .o_b_mag   (w_b_mag),
    .o_neg     (w_neg),
    .i_res_op  (r_op),
    .i_res_neg (r_neg),
    .i_acc     (w_acc_next),
    .o_result  (w_fixed)
  );

  // NOTE: datapath registers are reset along with the FSM so result_o is a known 0 out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else if (flush_i) begin
      // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            if (w_special) begin
              r_state  <= DONE;
              r_result <= w_special_res;
              r_valid  <= 1'b1;
            end else begin
              r_state <= CALC;
              r_op    <= alu_op_i;
              r_neg   <= w_neg;
              r_opnd  <= is_div_op(alu_op_i) ? w_b_mag : w_a_mag;
              r_acc   <= {{XLEN{1'b0}}, (is_div_op(alu_op_i) ? w_a_mag : w_b_mag)};
              r_cnt   <= '0;
            end
          end
        end
        CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= w_cnt_next;
          if (w_cnt_next == CNT_W'(XLEN)) begin
            r_state  <= DONE;
            r_result <= w_fixed;
            r_valid  <= 1'b1;
          end
        end
        DONE: begin
          if (!hold_i) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  a_start_is_mdu_op: assert property (
    @(posedge clk) disable iff (!reset)
    (start_i && !flush_i && (r_state == IDLE)) |-> is_mdu_op(alu_op_i)
  );

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scenario bench for ex_muldiv_unit: expected results are queued at issue and compared when
// result_valid_o rises, alongside stall length, hold, flush and reset behaviour.
module tb_ex_muldiv_unit;
  import riscv_pkg::*;

  localparam int          XLEN = 32;
  localparam logic [31:0] SMIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        hold_i = 1'b0;
  logic [4:0]  alu_op_i = '0;
  logic [31:0] operand_a_i = '0;
  logic [31:0] operand_b_i = '0;
  logic [31:0] result_o;
  logic        result_valid_o;
  logic        stall_o;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb_q[$];

  ex_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start_i),
    .flush_i        (flush_i),
    .hold_i         (hold_i),
    .alu_op_i       (alu_op_i),
    .operand_a_i    (operand_a_i),
    .operand_b_i    (operand_b_i),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .stall_o        (stall_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Behavioural RV32M reference using 64-bit host arithmetic.
  function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    longint      q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (op)
      ALU_MUL:    begin p = sa * sb; return p[31:0]; end
      ALU_MULH:   begin p = sa * sb; return p[63:32]; end
      ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
      ALU_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      ALU_DIV: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == SMIN && b == 32'hFFFF_FFFF) return SMIN;
        q = sa / sb;
        return q[31:0];
      end
      ALU_DIVU: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      ALU_REM: begin
        if (b == 32'h0) return a;
        if (a == SMIN && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb;
        return q[31:0];
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  // Issues one op (unit must be IDLE-bound), waits for its result, checks value, stall length,
  // optional hold period and that the valid pulse ends.
  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_stall,
                        input int hold_cycles, input bit keep_start);
    int          stall_cnt;
    bit          seen;
    logic [31:0] want;
    start_i     = 1'b1;
    alu_op_i    = op;
    operand_a_i = a;
    operand_b_i = b;
    sb_q.push_back(exp);
    #1;
    stall_cnt = 0;
    seen      = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (result_valid_o) begin
        seen = 1'b1;
      end else begin
        if (stall_o) stall_cnt++;
        @(negedge clk);
        #1;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: result_valid_o not seen within 200 cycles", name);
      want    = sb_q.pop_front();
      start_i = 1'b0;
      hold_i  = 1'b0;
      return;
    end
    want = sb_q.pop_front();
    checks++;
    if (result_o !== want) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", name, result_o, want);
    end
    checks++;
    if (stall_cnt != exp_stall) begin
      errors++;
      $display("FAIL %s stall length: got %0d cycles expected %0d", name, stall_cnt, exp_stall);
    end
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL %s stall in DONE: got %b expected 0", name, stall_o);
    end
    if (hold_cycles > 0) begin
      hold_i = 1'b1;
      for (int i = 1; i <= hold_cycles; i++) begin
        @(negedge clk);
        #1;
        if (i == hold_cycles) hold_i = 1'b0;
        checks++;
        if (result_valid_o !== 1'b1 || result_o !== want) begin
          errors++;
          $display("FAIL %s hold cycle %0d: got valid=%b result=%h expected valid=1 result=%h",
                   name, i, result_valid_o, result_o, want);
        end
      end
    end
    if (!keep_start) begin
      start_i = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (result_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL %s valid pulse end: got %b expected 0", name, result_valid_o);
      end
    end
  endtask

  task automatic test_reset;
    start_i  = 1'b1;
    alu_op_i = ALU_MUL;
    @(negedge clk);
    #1;
    checks++;
    if (result_o !== 32'h0 || result_valid_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got result=%h valid=%b stall=%b expected 0/0/0",
               result_o, result_valid_o, stall_o);
    end
    start_i = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (result_o !== 32'h0 || result_valid_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got result=%h valid=%b stall=%b expected 0/0/0",
               result_o, result_valid_o, stall_o);
    end
  endtask

  task automatic test_mul;
    run_op("mul_7_m3",    ALU_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0, 1'b0);
    run_op("mulhu_ff_ff", ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0, 1'b0);
    run_op("mulh_ff_ff",  ALU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 0, 1'b0);
    run_op("mulh_min_min", ALU_MULH,  SMIN,          SMIN,          32'h4000_0000, 33, 0, 1'b0);
  endtask

  task automatic test_div;
    run_op("div_m7_2",  ALU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0, 1'b0);
    run_op("rem_m7_2",  ALU_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0, 1'b0);
    run_op("divu_big",  ALU_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33, 0, 1'b0);
    run_op("remu_big",  ALU_REMU, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 33, 0, 1'b0);
  endtask

  task automatic test_special;
    run_op("divu_by0",     ALU_DIVU, 32'd1234, 32'd0,         32'hFFFF_FFFF, 1, 0, 1'b0);
    run_op("rem_5_by0",    ALU_REM,  32'd5,    32'd0,         32'd5,         1, 0, 1'b0);
    run_op("div_min_m1",   ALU_DIV,  SMIN,     32'hFFFF_FFFF, SMIN,          1, 0, 1'b0);
    run_op("rem_min_m1",   ALU_REM,  SMIN,     32'hFFFF_FFFF, 32'h0,         1, 0, 1'b0);
    run_op("div_by0",      ALU_DIV,  32'hFFFF_FF00, 32'd0,    32'hFFFF_FFFF, 1, 0, 1'b0);
  endtask

  task automatic test_flush;
    start_i     = 1'b1;
    alu_op_i    = ALU_MUL;
    operand_a_i = 32'd123;
    operand_b_i = 32'd456;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (stall_o !== 1'b1 || result_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_calc_state: got stall=%b valid=%b expected 1/0", stall_o, result_valid_o);
    end
    flush_i = 1'b1;
    @(negedge clk);
    #1;
    flush_i = 1'b0;
    start_i = 1'b0;
    #1;
    checks++;
    if (stall_o !== 1'b0 || result_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_to_idle: got stall=%b valid=%b expected 0/0", stall_o, result_valid_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (result_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_result: got valid=%b expected 0", result_valid_o);
    end
    run_op("flush_restart", ALU_DIVU, 32'd1000, 32'd7, 32'd142, 33, 0, 1'b0);
  endtask

  task automatic test_hold_reset;
    run_op("hold_mulhsu", ALU_MULHSU, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 33, 3, 1'b0);
    start_i     = 1'b1;
    alu_op_i    = ALU_DIV;
    operand_a_i = 32'd100;
    operand_b_i = 32'd3;
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (result_o !== 32'h0 || result_valid_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_midop: got result=%h valid=%b stall=%b expected 0/0/0",
               result_o, result_valid_o, stall_o);
    end
    @(negedge clk);
    start_i = 1'b0;
    reset   = 1'b1;
    #1;
    checks++;
    if (result_o !== 32'h0 || result_valid_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got result=%h valid=%b stall=%b expected 0/0/0",
               result_o, result_valid_o, stall_o);
    end
    @(negedge clk);
    #1;
    run_op("after_reset_rem", ALU_REM, 32'd100, 32'd3, 32'd1, 33, 0, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_op("b2b_first", ALU_MUL, 32'h1234_5678, 32'h9ABC_DEF0,
           ref_model(ALU_MUL, 32'h1234_5678, 32'h9ABC_DEF0), 33, 0, 1'b1);
    alu_op_i    = ALU_DIV;
    operand_a_i = 32'hFFFF_FF9C;
    operand_b_i = 32'd7;
    #1;
    checks++;
    if (stall_o !== 1'b0 || result_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done_ignores_start: got stall=%b valid=%b expected 0/1", stall_o, result_valid_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (stall_o !== 1'b1 || result_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_restart: got stall=%b valid=%b expected 1/0", stall_o, result_valid_o);
    end
    run_op("b2b_second", ALU_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, 0, 1'b0);
  endtask

  task automatic test_random;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          exp_stall;
    for (int i = 0; i < 8; i++) begin
      op = ALU_MUL + 5'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i == 5) ? 32'h0 : $urandom;
      exp_stall = 33;
      if (op[2] && (b == 32'h0)) exp_stall = 1;
      if ((op == ALU_DIV || op == ALU_REM) && a == SMIN && b == 32'hFFFF_FFFF) exp_stall = 1;
      run_op($sformatf("random_%0d_op%b", i, op), op, a, b, ref_model(op, a, b), exp_stall, 0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_hold_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
